i2s_audio_tx: RTL and testbench
===============================

# i2s_audio_tx

Stereo I2S serializer between the guest core's 16-bit audio samples and the board's `I2S_BCK`/`I2S_LRCK`/`I2S_DATA` pins on the UAReloaded top level. It runs from the 50 MHz system clock and generates bit clock and word select itself, acting as I2S master. Samples enter through a one-deep valid/ready holding register. At each frame boundary the block loads a new frame, or repeats the previous frame on underrun.

## Interface
- `BCK_DIV`, 8, half-period of `i2s_bck` in `clk` cycles (≥2). At 50 MHz the default gives 3.125 MHz BCK and fs = 48 828 Hz.
- `SIGNED_IN`, 1: 1 means inputs are two's complement; 0 means inputs are offset-binary, converted by inverting bit 15 at capture.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, synchronous and active-low.
- `in_left`  in  16  left sample.
- `in_right`  in  16  right sample.
- `in_valid`  in  1  sample pair is valid.
- `in_ready`  out  1  holding register is empty; transfer occurs when `in_valid && in_ready`.
- `underrun`  out  1  one-cycle pulse when a frame repeats because no new pair was held.
- `i2s_bck`  out  1  bit clock.
- `i2s_lrck`  out  1  word select: 0 = left, 1 = right.
- `i2s_data`  out  1  serial data, MSB first, Philips I2S alignment.

## Operation
- Divider `div_cnt` counts 0..BCK_DIV-1.
  - On its terminal count `i2s_bck` toggles and `div_cnt` returns to 0.
  - The cycle in which `i2s_bck` goes 1→0 is the *fall strobe*.
- Position counter `pos` is 6 bits, 0..63. It increments modulo 64 on each fall strobe. One frame is 64 BCK: 32 slots per channel.
- Outputs are registered and update in the fall-strobe cycle from the new `pos`:
  - `i2s_lrck` = `pos[5]`.
  - Let s = `pos[4:0]`. For s in 1..16, `i2s_data` = bit (16−s) of the current channel word (left if `pos[5]`=0, otherwise right). For all other s, `i2s_data` = 0.
- Frame load happens in the fall-strobe cycle where `pos` wraps 63→0:
  - If the holding register is full, `frame_l`/`frame_r` take the held pair and the holding register empties.
  - Otherwise the frame registers keep their value and `underrun` pulses high for that one cycle.
- Holding register:
  - Written on a transfer; `SIGNED_IN`=0 inversion is applied at this point.
  - `in_ready` = not full, registered.
- Simultaneous events:
  - A transfer in the load cycle while the holding register is empty is captured into the holding register. It is not used for the current frame, and `underrun` still pulses.
  - When the holding register is full in the load cycle, `in_ready` is 0, so no transfer can collide.
- Reset (including mid-frame), applied on the next `clk` edge:
  - `div_cnt`=0, `i2s_bck`=0, `pos`=63, `i2s_lrck`=1, `i2s_data`=0.
  - `frame_l`=`frame_r`=0, holding register empty, `in_ready`=1, `underrun`=0.
  - The in-flight frame and any held sample are discarded.

## Timing
- With BCK_DIV=N, the first `i2s_bck` rise is N cycles after the first clock with `reset_n`=1. The first fall strobe is at 2N cycles; `pos` wraps to 0, a frame loads, and `i2s_lrck` goes 0.
- MSB of left appears on the second fall strobe, at 4N cycles; LSB of left on the 17th fall strobe.
- Right MSB is on the fall strobe at `pos`=33. The receiver samples on `i2s_bck` rising edges.
- Frame period is 128·N clk (1024 at N=8).
- `in_ready` returns to 1 one cycle after the load cycle.
- `underrun` is high for exactly 1 clk per missed frame.
- The data path from `in_*` to the first serialized bit takes at most 128·N + 2N cycles.

## Structure
- Package `i2s_pkg`: `SAMPLE_W`=16, `SLOT_W`=32, `FRAME_BCK`=64, and a typedef for the stereo sample pair struct.
- Sub-module `i2s_bck_gen`: divider producing `i2s_bck` and the fall strobe.
- The top level holds the handshake register, frame registers, `pos`, and the output mux.

## Test plan
- Reset release with no input, N=8:
  - `i2s_lrck` falls at cycle 16.
  - `underrun` pulses at cycle 16 and again every 1024 cycles.
  - `i2s_data` is constantly 0.
- Single pair L=16'hA5C3, R=16'h5A3C, offered before cycle 16:
  - `in_ready` drops, then rises at cycle 17.
  - Bits sampled on `i2s_bck` rise after the `i2s_lrck` fall are 0, A5C3 MSB first, then 15 zeros.
  - After the `i2s_lrck` rise the bits are 0, 5A3C, then zeros.
  - No `underrun` pulse for that frame.
- Back-to-back pairs P1, P2, P3 with `in_valid` held high:
  - P2 stalls (`in_ready`=0) until the frame-1 load.
  - Each frame carries P1, P2, P3 in order, with no drops or duplicates.
- Starvation after P1: frame 2 repeats P1 and `underrun`=1 for exactly one cycle at its load.
- `reset_n` asserted low for 1 cycle at `pos`=20 with a held pair:
  - Next cycle shows `i2s_bck`=0, `i2s_lrck`=1, `i2s_data`=0, `in_ready`=1.
  - The held pair never appears on `i2s_data`.
- `SIGNED_IN`=0, input L=16'h0000: serialized left word is 16'h8000.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants, the stereo sample pair type and the input
// format helper for the i2s_audio_tx serializer.
package i2s_pkg;

  localparam int SAMPLE_W  = 16;  // audio word width
  localparam int SLOT_W    = 32;  // BCK periods per channel slot
  localparam int FRAME_BCK = 64;  // BCK periods per stereo frame

  localparam int POS_W      = $clog2(FRAME_BCK);  // frame position counter width
  localparam int SLOT_IDX_W = $clog2(SLOT_W);     // position within a slot

  localparam logic [POS_W-1:0] POS_LAST = 6'd63;  // last position of a frame

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  localparam stereo_t STEREO_ZERO = '{left: 16'h0000, right: 16'h0000};

  // Offset-binary input becomes two's complement by flipping the sign bit.
  function automatic logic [SAMPLE_W-1:0] to_twos(input logic [SAMPLE_W-1:0] s,
                                                  input logic              signed_in);
    logic [SAMPLE_W-1:0] r;
    if (signed_in) begin
      r = s;
    end else begin
      r = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// i2s_bck_gen: divides clk down to the I2S bit clock.
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   i2s_bck  out bit clock, toggles every BCK_DIV clk cycles, 0 after reset
//   fall_stb out high in the clk cycle whose edge drives i2s_bck 1->0
module i2s_bck_gen #(
  parameter int BCK_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  output logic i2s_bck,
  output logic fall_stb
);

  logic [7:0] div_cnt_r;
  logic       bck_r;
  logic       tc_s;

  assign tc_s     = (div_cnt_r == 8'(BCK_DIV - 1));
  // Terminal count while high means the coming edge is the falling one.
  assign fall_stb = tc_s & bck_r;
  assign i2s_bck  = bck_r;

  // Half-period divider and bit clock toggle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_r <= 8'd0;
      bck_r     <= 1'b0;
    end else if (tc_s) begin
      div_cnt_r <= 8'd0;
      bck_r     <= ~bck_r;
    end else begin
      div_cnt_r <= div_cnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: stereo 16-bit I2S master serializer (Philips alignment,
// 32 BCK per channel slot, MSB one BCK after the word-select change).
//   clk       in  system clock, the only clock
//   reset_n   in  synchronous active-low reset
//   in_left   in  left sample
//   in_right  in  right sample
//   in_valid  in  sample pair valid
//   in_ready  out holding register empty; transfer on in_valid && in_ready
//   underrun  out one-cycle pulse when a frame repeats for lack of a new pair
//   i2s_bck   out bit clock
//   i2s_lrck  out word select, 0 = left, 1 = right
//   i2s_data  out serial data, MSB first
module i2s_audio_tx
  import i2s_pkg::*;
#(
  parameter int BCK_DIV   = 8,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                underrun,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  logic                  fall_stb_s;
  logic                  bck_s;
  logic                  xfer_s;
  logic                  load_s;
  stereo_t               capture_s;
  stereo_t               hold_r;
  stereo_t               frame_r;
  logic                  full_r;
  logic                  in_ready_r;
  logic                  underrun_r;
  logic                  lrck_r;
  logic                  data_r;
  logic [POS_W-1:0]      pos_r;
  logic [POS_W-1:0]      pos_next_s;
  logic [SLOT_IDX_W-1:0] slot_s;
  logic [3:0]            bit_idx_s;
  logic [SAMPLE_W-1:0]   word_s;
  logic                  data_next_s;

  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .i2s_bck  (bck_s),
    .fall_stb (fall_stb_s)
  );

  assign xfer_s          = in_valid & in_ready_r;
  assign load_s          = fall_stb_s & (pos_r == POS_LAST);
  assign capture_s.left  = to_twos(in_left, SIGNED_IN);
  assign capture_s.right = to_twos(in_right, SIGNED_IN);

  // Serial bit for the position the next fall strobe moves to.
  always_comb begin
    pos_next_s  = pos_r + 6'd1;
    slot_s      = pos_next_s[SLOT_IDX_W-1:0];
    // Slot positions 1..16 carry bits 15..0; ~(s-1) maps 1->15 .. 16->0.
    bit_idx_s   = ~(slot_s[3:0] - 4'd1);
    word_s      = frame_r.left;
    data_next_s = 1'b0;
    if (pos_next_s[POS_W-1]) begin
      word_s = frame_r.right;
    end else begin
      word_s = frame_r.left;
    end
    if ((slot_s >= 5'd1) && (slot_s <= 5'd16)) begin
      data_next_s = word_s[bit_idx_s];
    end else begin
      data_next_s = 1'b0;
    end
  end

  // One-deep holding register with its ready flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_r     <= STEREO_ZERO;
      full_r     <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      // Ready drops with the transfer but only reopens the cycle after a
      // load, since it follows the previous full flag.
      in_ready_r <= ~full_r & ~xfer_s;
      if (xfer_s) begin
        hold_r <= capture_s;
        full_r <= 1'b1;
      end else if (load_s && full_r) begin
        full_r <= 1'b0;
      end
    end
  end

  // Frame position, frame load and the registered serial outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_r      <= POS_LAST;
      lrck_r     <= 1'b1;
      data_r     <= 1'b0;
      frame_r    <= STEREO_ZERO;
      underrun_r <= 1'b0;
    end else begin
      // A transfer landing in the load cycle only fills the holding
      // register, so the empty check still reports an underrun.
      underrun_r <= load_s & ~full_r;
      if (fall_stb_s) begin
        pos_r  <= pos_next_s;
        lrck_r <= pos_next_s[POS_W-1];
        data_r <= data_next_s;
      end
      if (load_s && full_r) begin
        frame_r <= hold_r;
      end
    end
  end

  assign in_ready = in_ready_r;
  assign underrun = underrun_r;
  assign i2s_bck  = bck_s;
  assign i2s_lrck = lrck_r;
  assign i2s_data = data_r;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx with BCK_DIV=8: one instance takes
// two's complement input, a second identical one takes offset binary.
// A small receiver captures 32-bit slots on i2s_bck rising edges.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_left = 16'h0000;
  logic [15:0] in_right = 16'h0000;
  logic        in_valid = 1'b0;

  logic a_ready, a_ur, a_bck, a_lrck, a_data;
  logic b_ready, b_ur, b_bck, b_lrck, b_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  i2s_audio_tx #(.BCK_DIV(8), .SIGNED_IN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(a_ready), .underrun(a_ur),
    .i2s_bck(a_bck), .i2s_lrck(a_lrck), .i2s_data(a_data)
  );

  i2s_audio_tx #(.BCK_DIV(8), .SIGNED_IN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(b_ready), .underrun(b_ur),
    .i2s_bck(b_bck), .i2s_lrck(b_lrck), .i2s_data(b_data)
  );

  // ---------------- receiver ----------------
  logic [31:0] sh_a = 32'd0;
  logic [31:0] sh_b = 32'd0;
  int          rx_cnt = 0;
  logic        prev_lrck = 1'b1;
  logic [31:0] rxa_l[$];
  logic [31:0] rxa_r[$];
  logic [31:0] rxb_l[$];
  logic [31:0] rxb_r[$];

  // Collect one slot per word-select phase; keep only complete 32-bit slots.
  always @(posedge a_bck) begin
    if (a_lrck != prev_lrck) begin
      if (rx_cnt == 32) begin
        if (prev_lrck) begin
          rxa_r.push_back(sh_a);
          rxb_r.push_back(sh_b);
        end else begin
          rxa_l.push_back(sh_a);
          rxb_l.push_back(sh_b);
        end
      end
      rx_cnt <= 1;
      sh_a   <= {31'd0, a_data};
      sh_b   <= {31'd0, b_data};
    end else begin
      rx_cnt <= (rx_cnt < 40) ? rx_cnt + 1 : rx_cnt;
      sh_a   <= {sh_a[30:0], a_data};
      sh_b   <= {sh_b[30:0], b_data};
    end
    prev_lrck <= a_lrck;
  end

  // ---------------- bench state ----------------
  int          cyc = 0;
  int          ur_hits = 0;
  int          ur_first = -1;
  int          ur_last = -1;
  int          ones_a = 0;
  int          xfer_cyc[$];
  logic [15:0] feed_l[$];
  logic [15:0] feed_r[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // A complete I2S slot carrying word w.
  function automatic logic [31:0] slot_of(input logic [15:0] w);
    return {1'b0, w, 15'd0};
  endfunction

  // Missing slots read as all ones, which no real slot can equal.
  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic drive_next();
    if (feed_l.size() > 0) begin
      in_left  = feed_l[0];
      in_right = feed_r[0];
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    feed_l.push_back(l);
    feed_r.push_back(r);
    if (!in_valid) drive_next();
  endtask

  // Advance to the next falling clk edge; cyc is the count of rising edges
  // since reset release, so values seen here are those driven by edge cyc.
  task automatic step();
    logic fire;
    fire = in_valid && a_ready;
    @(negedge clk);
    cyc++;
    if (a_ur) begin
      ur_hits++;
      if (ur_hits == 1) ur_first = cyc;
      ur_last = cyc;
    end
    if (a_data) ones_a++;
    if (fire) begin
      xfer_cyc.push_back(cyc);
      void'(feed_l.pop_front());
      void'(feed_r.pop_front());
      drive_next();
    end
  endtask

  task automatic hold_reset(input int n);
    reset_n = 1'b0;
    in_valid = 1'b0;
    feed_l.delete();
    feed_r.delete();
    repeat (n) @(negedge clk);
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    cyc = 0;
    ur_hits = 0;
    ur_first = -1;
    ur_last = -1;
    ones_a = 0;
    xfer_cyc.delete();
    rxa_l.delete();
    rxa_r.delete();
    rxb_l.delete();
    rxb_r.delete();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  initial begin
    // ---- reset state, then idle with no input ----
    hold_reset(3);
    check_eq("rst_bck", 32'(a_bck), 32'd0);
    check_eq("rst_lrck", 32'(a_lrck), 32'd1);
    check_eq("rst_data", 32'(a_data), 32'd0);
    check_eq("rst_ready", 32'(a_ready), 32'd1);
    check_eq("rst_underrun", 32'(a_ur), 32'd0);
    release_reset();
    while (cyc < 1050) begin
      step();
      if (cyc == 7)  check_eq("idle_bck_c7", 32'(a_bck), 32'd0);
      if (cyc == 8)  check_eq("idle_bck_c8", 32'(a_bck), 32'd1);
      if (cyc == 15) check_eq("idle_lrck_c15", 32'(a_lrck), 32'd1);
      if (cyc == 16) check_eq("idle_lrck_c16", 32'(a_lrck), 32'd0);
    end
    check_eq("idle_ur_hits", 32'(ur_hits), 32'd2);
    check_eq("idle_ur_first", 32'(ur_first), 32'd16);
    check_eq("idle_ur_last", 32'(ur_last), 32'd1040);
    check_eq("idle_data_ones", 32'(ones_a), 32'd0);

    // ---- single pair, then starvation repeats it ----
    hold_reset(2);
    release_reset();
    offer(16'hA5C3, 16'h5A3C);
    while (cyc < 1600) begin
      step();
      if (cyc == 1)  check_eq("one_ready_c1", 32'(a_ready), 32'd0);
      if (cyc == 16) check_eq("one_ready_c16", 32'(a_ready), 32'd0);
      if (cyc == 17) check_eq("one_ready_c17", 32'(a_ready), 32'd1);
    end
    check_eq("one_xfer_cyc", 32'(xfer_cyc.size() > 0 ? xfer_cyc[0] : -1), 32'd1);
    check_eq("one_left", q_at(rxa_l, 0), slot_of(16'hA5C3));
    check_eq("one_right", q_at(rxa_r, 0), slot_of(16'h5A3C));
    check_eq("one_repeat_left", q_at(rxa_l, 1), slot_of(16'hA5C3));
    check_eq("one_ur_hits", 32'(ur_hits), 32'd1);
    check_eq("one_ur_at", 32'(ur_first), 32'd1040);
    check_eq("one_unsigned_left", q_at(rxb_l, 0), slot_of(16'h25C3));

    // ---- back-to-back pairs with in_valid held ----
    hold_reset(2);
    release_reset();
    offer(16'h1234, 16'hFEDC);
    offer(16'h8001, 16'h7FFE);
    offer(16'hC0DE, 16'h0F0F);
    run_to(3120);
    check_eq("b2b_xfer0", 32'(xfer_cyc.size() > 0 ? xfer_cyc[0] : -1), 32'd1);
    check_eq("b2b_xfer1", 32'(xfer_cyc.size() > 1 ? xfer_cyc[1] : -1), 32'd18);
    check_eq("b2b_xfer2", 32'(xfer_cyc.size() > 2 ? xfer_cyc[2] : -1), 32'd1042);
    check_eq("b2b_l0", q_at(rxa_l, 0), slot_of(16'h1234));
    check_eq("b2b_r0", q_at(rxa_r, 0), slot_of(16'hFEDC));
    check_eq("b2b_l1", q_at(rxa_l, 1), slot_of(16'h8001));
    check_eq("b2b_r1", q_at(rxa_r, 1), slot_of(16'h7FFE));
    check_eq("b2b_l2", q_at(rxa_l, 2), slot_of(16'hC0DE));
    check_eq("b2b_r2", q_at(rxa_r, 2), slot_of(16'h0F0F));
    check_eq("b2b_ur_hits", 32'(ur_hits), 32'd1);
    check_eq("b2b_ur_at", 32'(ur_first), 32'd3088);

    // ---- mid-frame reset with a pair held ----
    hold_reset(2);
    release_reset();
    offer(16'h1111, 16'h2222);
    offer(16'hDEAD, 16'hBEEF);
    run_to(340);
    check_eq("mid_held_ready", 32'(a_ready), 32'd0);
    hold_reset(1);
    check_eq("mid_rst_bck", 32'(a_bck), 32'd0);
    check_eq("mid_rst_lrck", 32'(a_lrck), 32'd1);
    check_eq("mid_rst_data", 32'(a_data), 32'd0);
    check_eq("mid_rst_ready", 32'(a_ready), 32'd1);
    release_reset();
    run_to(1600);
    check_eq("mid_ur_first", 32'(ur_first), 32'd16);
    check_eq("mid_ur_hits", 32'(ur_hits), 32'd2);
    check_eq("mid_left", q_at(rxa_l, 0), slot_of(16'h0000));
    check_eq("mid_right", q_at(rxa_r, 0), slot_of(16'h0000));
    check_eq("mid_data_ones", 32'(ones_a), 32'd0);

    // ---- offset-binary conversion ----
    hold_reset(2);
    release_reset();
    offer(16'h0000, 16'hFFFF);
    run_to(1100);
    check_eq("ob_left", q_at(rxb_l, 0), slot_of(16'h8000));
    check_eq("ob_right", q_at(rxb_r, 0), slot_of(16'h7FFF));
    check_eq("tc_right", q_at(rxa_r, 0), slot_of(16'hFFFF));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
